// File: rtl/alu_nibble_sequencer.sv
// Sequences a wide ALU op through one 4-bit 74181-style slice, LS nibble first, rippling carry.
// Valid NIBBLES edges after accept; result held under out_ready backpressure, in_ready low while busy.
module alu_nibble_sequencer #(
    parameter  int NIBBLES = 4,
    localparam int W       = 4 * NIBBLES,
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic [3:0]   op_s,
    input  logic         op_m,
    input  logic         op_cn,
    output logic [3:0]   slice_a,
    output logic [3:0]   slice_b,
    output logic [3:0]   slice_s,
    output logic         slice_m,
    output logic         slice_cn,
    input  logic [3:0]   slice_f,
    input  logic         slice_cout,
    input  logic         slice_eq,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_f,
    output logic         out_cout,
    output logic         out_eq
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                    state_q;
    logic [NIBBLES-1:0][3:0]   a_q;
    logic [NIBBLES-1:0][3:0]   b_q;
    logic [NIBBLES-1:0][3:0]   f_q;
    logic [3:0]                s_q;
    logic                      m_q;
    logic                      carry_q;
    logic                      eq_q;
    logic [IDX_W-1:0]          idx_q;
    logic                      in_ready_q;
    logic                      out_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            f_q         <= '0;
            s_q         <= 4'h0;
            m_q         <= 1'b0;
            carry_q     <= 1'b1;
            eq_q        <= 1'b0;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= op_a;
                        b_q        <= op_b;
                        s_q        <= op_s;
                        m_q        <= op_m;
                        carry_q    <= op_cn;
                        eq_q       <= 1'b1;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    f_q[idx_q] <= slice_f;
                    carry_q    <= slice_cout;
                    eq_q       <= eq_q & slice_eq;
                    // idx parks on the last nibble rather than wrapping
                    if (idx_q == IDX_W'(NIBBLES - 1)) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_f     = f_q;
    assign out_cout  = carry_q;
    assign out_eq    = eq_q;

    // Operand nibbles are forced to zero outside RUN so the slice sees a quiet bus
    assign slice_a  = (state_q == RUN) ? a_q[idx_q] : 4'h0;
    assign slice_b  = (state_q == RUN) ? b_q[idx_q] : 4'h0;
    assign slice_s  = s_q;
    assign slice_m  = m_q;
    assign slice_cn = carry_q;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for alu_nibble_sequencer: behavioural slice model, directed ops, scoreboard monitor.
module tb_alu_nibble_sequencer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [3:0]  op_s;
    logic        op_m;
    logic        op_cn;
    logic [3:0]  slice_a;
    logic [3:0]  slice_b;
    logic [3:0]  slice_s;
    logic        slice_m;
    logic        slice_cn;
    logic [3:0]  slice_f;
    logic        slice_cout;
    logic        slice_eq;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_f;
    logic        out_cout;
    logic        out_eq;

    alu_nibble_sequencer #(.NIBBLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_s       (op_s),
        .op_m       (op_m),
        .op_cn      (op_cn),
        .slice_a    (slice_a),
        .slice_b    (slice_b),
        .slice_s    (slice_s),
        .slice_m    (slice_m),
        .slice_cn   (slice_cn),
        .slice_f    (slice_f),
        .slice_cout (slice_cout),
        .slice_eq   (slice_eq),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_f      (out_f),
        .out_cout   (out_cout),
        .out_eq     (out_eq)
    );

    // Slice model covering the functions used here: A plus B, A minus B minus 1, XOR
    logic [4:0] sum;
    logic       cin;
    always_comb begin
        sum        = 5'h0;
        cin        = ~slice_cn;
        slice_cout = 1'b1;
        if (!slice_m && slice_s == 4'b1001) begin
            sum        = {1'b0, slice_a} + {1'b0, slice_b} + {4'h0, cin};
            slice_cout = ~sum[4];
        end else if (!slice_m && slice_s == 4'b0110) begin
            sum        = {1'b0, slice_a} + {1'b0, ~slice_b} + {4'h0, cin};
            slice_cout = ~sum[4];
        end else begin
            sum = {1'b0, slice_a ^ slice_b};
        end
        slice_f  = sum[3:0];
        slice_eq = &sum[3:0];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] f;
        logic        cout;
        logic        eq;
        bit          chk_cout;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] a_log[$];
    logic       cn_log[$];
    int         accept_cyc = 0;
    int         n_checks   = 0;
    int         n_errors   = 0;
    logic       prev_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: logs slice traffic during RUN, checks latency, pops scoreboard on handshake
    always @(negedge clk) begin
        if (!rst && !in_ready && !out_valid) begin
            a_log.push_back(slice_a);
            cn_log.push_back(slice_cn);
        end
        if (out_valid && !prev_valid)
            chk("latency", 32'(cyc - accept_cyc), 32'd4);
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_f", 32'(out_f), 32'(e.f));
                if (e.chk_cout) chk("out_cout", 32'(out_cout), 32'(e.cout));
                chk("out_eq", 32'(out_eq), 32'(e.eq));
            end
        end
        prev_valid = out_valid;
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                        input logic m, input logic cn, input bit push,
                        input logic [15:0] ef, input logic ec, input logic ee, input bit cc);
        exp_t e;
        @(negedge clk);
        a_log.delete();
        cn_log.delete();
        op_a = a; op_b = b; op_s = s; op_m = m; op_cn = cn;
        in_valid = 1'b1;
        chk("in_ready_at_accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        if (push) begin
            e.f = ef; e.cout = ec; e.eq = ee; e.chk_cout = cc;
            sb.push_back(e);
        end
        in_valid = 1'b0;
        op_a = ~a; op_b = ~b; op_s = ~s; op_m = ~m; op_cn = ~cn;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && in_ready && !out_valid) done = 1'b1;
        end
        chk("idle_timeout", 32'(done), 32'd1);
    endtask

    task automatic check_rst_vals(input string tag);
        chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_f"},     32'(out_f),     32'd0);
        chk({tag, "_out_cout"},  32'(out_cout),  32'd1);
        chk({tag, "_out_eq"},    32'(out_eq),    32'd0);
        chk({tag, "_slice_a"},   32'(slice_a),   32'd0);
        chk({tag, "_slice_b"},   32'(slice_b),   32'd0);
        chk({tag, "_slice_s"},   32'(slice_s),   32'd0);
        chk({tag, "_slice_m"},   32'(slice_m),   32'd0);
        chk({tag, "_slice_cn"},  32'(slice_cn),  32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op_a = '0; op_b = '0; op_s = '0; op_m = 1'b0; op_cn = 1'b1;
        repeat (2) @(negedge clk);
        check_rst_vals("por");
        rst = 1'b0;

        // 0x1234 + 0x0FFF
        send(16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b1, 1'b1, 16'h2233, 1'b1, 1'b0, 1'b1);
        wait_idle();
        chk("a_log_len", 32'(a_log.size()), 32'd4);
        if (a_log.size() == 4) begin
            chk("slice_a0", 32'(a_log[0]), 32'd4);
            chk("slice_a1", 32'(a_log[1]), 32'd3);
            chk("slice_a2", 32'(a_log[2]), 32'd2);
            chk("slice_a3", 32'(a_log[3]), 32'd1);
        end

        // 0xFFFF + 0x0001 carries out of every nibble
        send(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
        wait_idle();
        chk("cn_log_len", 32'(cn_log.size()), 32'd4);
        if (cn_log.size() == 4) begin
            chk("slice_cn0", 32'(cn_log[0]), 32'd1);
            chk("slice_cn1", 32'(cn_log[1]), 32'd0);
            chk("slice_cn2", 32'(cn_log[2]), 32'd0);
            chk("slice_cn3", 32'(cn_log[3]), 32'd0);
        end

        // Compare equal / unequal, then logic XOR
        send(16'hBEEF, 16'hBEEF, 4'b0110, 1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b1);
        wait_idle();
        send(16'hBEEF, 16'hBEEE, 4'b0110, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
        wait_idle();
        send(16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1, 1'b1, 16'h0FF0, 1'b1, 1'b0, 1'b0);
        wait_idle();

        // Backpressure with a dropped request attempt
        out_ready = 1'b0;
        send(16'h1111, 16'h2222, 4'b1001, 1'b0, 1'b1, 1'b1, 16'h3333, 1'b1, 1'b0, 1'b1);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (out_valid) seen = 1'b1;
            end
            chk("bp_valid_timeout", 32'(seen), 32'd1);
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                op_a = 16'hAAAA; op_b = 16'h5555; op_s = 4'b1001; op_m = 1'b0; op_cn = 1'b1;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_f",     32'(out_f),     32'h3333);
            chk("bp_in_ready",  32'(in_ready),  32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready_after", 32'(in_ready),  32'd1);
        chk("bp_valid_after",    32'(out_valid), 32'd0);
        wait_idle();
        repeat (8) @(negedge clk);

        // Abort after two RUN edges
        send(16'h5555, 16'h1111, 4'b1001, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1 check_rst_vals("abort");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("abort_no_valid", 32'(out_valid), 32'd0);

        send(16'h0001, 16'h0001, 4'b1001, 1'b0, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b1);
        wait_idle();
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
